// File: rtl/uart_command_decoder.sv
// Two-byte UART command framer: a command byte then a sensor address byte, presented
// on a valid/ready handshake with a timeout between the two bytes.
module uart_command_decoder #(
    parameter int         TIMEOUT_CLOCKS = 100000,
    parameter logic [7:0] LAST_CMD       = 8'h07
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       has_data,
    input  logic [7:0] data_received,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic [4:0] sensor_addr,
    output logic       frame_error,
    output logic [1:0] error_kind,
    output logic       overrun,
    output logic       busy
);

    // A one-clock timeout still needs a one-bit timer.
    localparam int TIMER_W = (TIMEOUT_CLOCKS > 1) ? $clog2(TIMEOUT_CLOCKS) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CLOCKS - 1);

    localparam logic [1:0] ERR_CMD     = 2'b01;
    localparam logic [1:0] ERR_ADDR    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ADDR = 2'd1,
        ISSUE     = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic [7:0]         cmd_code_nxt;
    logic [4:0]         sensor_addr_nxt;
    logic [1:0]         error_kind_nxt;
    logic               frame_error_nxt;
    logic               overrun_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            timer       <= '0;
            cmd_code    <= '0;
            sensor_addr <= '0;
            error_kind  <= '0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            cmd_code    <= cmd_code_nxt;
            sensor_addr <= sensor_addr_nxt;
            error_kind  <= error_kind_nxt;
            frame_error <= frame_error_nxt;
            overrun     <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        timer_nxt       = timer;
        cmd_code_nxt    = cmd_code;
        sensor_addr_nxt = sensor_addr;
        error_kind_nxt  = error_kind;
        frame_error_nxt = 1'b0;
        overrun_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (has_data) begin
                    if (data_received <= LAST_CMD) begin
                        cmd_code_nxt = data_received;
                        timer_nxt    = '0;
                        state_nxt    = WAIT_ADDR;
                    end else begin
                        frame_error_nxt = 1'b1;
                        error_kind_nxt  = ERR_CMD;
                    end
                end
            end
            WAIT_ADDR: begin
                // An arriving byte takes priority over an expiring timer.
                if (has_data) begin
                    if (data_received[7:5] == 3'b000) begin
                        sensor_addr_nxt = data_received[4:0];
                        state_nxt       = ISSUE;
                    end else begin
                        frame_error_nxt = 1'b1;
                        error_kind_nxt  = ERR_ADDR;
                        state_nxt       = IDLE;
                    end
                end else if (timer == TIMER_LAST) begin
                    frame_error_nxt = 1'b1;
                    error_kind_nxt  = ERR_TIMEOUT;
                    state_nxt       = IDLE;
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                end
            end
            ISSUE: begin
                // Bytes arriving while a command is pending are dropped, even on the transfer edge.
                overrun_nxt = has_data;
                if (cmd_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_valid = (state == ISSUE);
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_uart_command_decoder.sv
// Self-checking bench for uart_command_decoder: expected commands are queued when the
// address byte is driven and compared when the handshake transfers them.
module tb_uart_command_decoder;

    localparam int TIMEOUT = 16;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       has_data;
    logic [7:0] data_received;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic [4:0] sensor_addr;
    logic       frame_error;
    logic [1:0] error_kind;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [12:0] exp_q[$];

    uart_command_decoder #(
        .TIMEOUT_CLOCKS(TIMEOUT),
        .LAST_CMD      (8'h07)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .has_data     (has_data),
        .data_received(data_received),
        .cmd_ready    (cmd_ready),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .sensor_addr  (sensor_addr),
        .frame_error  (frame_error),
        .error_kind   (error_kind),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Handshake monitor: a transfer happens on the next rising edge when both are high.
    always @(negedge clock) begin
        if (reset_n && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_xfer", {19'd0, cmd_code, sensor_addr}, 32'h1FFFF);
            end else begin
                check_eq("xfer", {19'd0, cmd_code, sensor_addr}, {19'd0, exp_q.pop_front()});
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        has_data      = 1'b1;
        data_received = b;
        @(posedge clock);
        #1;
        has_data      = 1'b0;
        data_received = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_outs"}, {cmd_valid, cmd_code, sensor_addr, frame_error, error_kind, overrun, busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        has_data      = 1'b0;
        data_received = 8'h00;
        cmd_ready     = 1'b0;
        #12;
        check_all_zero("reset");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(1);

        // Basic frame 0x03 / 0x11
        cmd_ready = 1'b1;
        strobe(8'h03);
        check_eq("b1_busy", busy, 1);
        check_eq("b1_valid", cmd_valid, 0);
        exp_q.push_back({8'h03, 5'h11});
        strobe(8'h11);
        check_eq("b1_valid_on", cmd_valid, 1);
        check_eq("b1_code", cmd_code, 8'h03);
        check_eq("b1_addr", sensor_addr, 5'h11);
        idle(1);
        check_eq("b1_valid_off", cmd_valid, 0);
        check_eq("b1_busy_off", busy, 0);
        check_eq("b1_code_hold", cmd_code, 8'h03);

        // Bad command byte, then a good frame
        strobe(8'h09);
        check_eq("bc_fe", frame_error, 1);
        check_eq("bc_kind", error_kind, 2'b01);
        check_eq("bc_busy", busy, 0);
        idle(1);
        check_eq("bc_fe_pulse", frame_error, 0);
        strobe(8'h01);
        exp_q.push_back({8'h01, 5'h02});
        strobe(8'h02);
        check_eq("bc_valid", cmd_valid, 1);
        idle(1);
        check_eq("bc_kind_held", error_kind, 2'b01);

        // Bad address byte
        strobe(8'h02);
        strobe(8'h40);
        check_eq("ba_fe", frame_error, 1);
        check_eq("ba_kind", error_kind, 2'b10);
        check_eq("ba_valid", cmd_valid, 0);
        check_eq("ba_busy", busy, 0);
        idle(2);

        // Timeout: error exactly TIMEOUT clocks after the command strobe
        strobe(8'h04);
        idle(TIMEOUT - 1);
        check_eq("to_fe_early", frame_error, 0);
        check_eq("to_busy_early", busy, 1);
        idle(1);
        check_eq("to_fe", frame_error, 1);
        check_eq("to_kind", error_kind, 2'b11);
        check_eq("to_busy", busy, 0);
        idle(1);
        check_eq("to_fe_pulse", frame_error, 0);

        // Address byte on the final cycle wins over the timeout
        strobe(8'h04);
        idle(TIMEOUT - 1);
        exp_q.push_back({8'h04, 5'h0A});
        strobe(8'h0A);
        check_eq("tl_fe", frame_error, 0);
        check_eq("tl_valid", cmd_valid, 1);
        check_eq("tl_kind_held", error_kind, 2'b11);
        idle(1);

        // Back-pressure with an overrun byte
        cmd_ready = 1'b0;
        strobe(8'h05);
        exp_q.push_back({8'h05, 5'h1F});
        strobe(8'h1F);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                strobe(8'hAA);
                check_eq("bp_overrun", overrun, 1);
            end else begin
                idle(1);
                check_eq("bp_no_overrun", overrun, 0);
            end
            check_eq("bp_valid", cmd_valid, 1);
            check_eq("bp_code", cmd_code, 8'h05);
            check_eq("bp_addr", sensor_addr, 5'h1F);
        end
        cmd_ready = 1'b1;
        idle(1);
        check_eq("bp_valid_off", cmd_valid, 0);
        check_eq("bp_busy_off", busy, 0);
        check_eq("bp_addr_hold", sensor_addr, 5'h1F);

        // Byte on the transfer edge is an overrun and is discarded
        cmd_ready = 1'b0;
        strobe(8'h06);
        exp_q.push_back({8'h06, 5'h07});
        strobe(8'h07);
        cmd_ready = 1'b1;
        strobe(8'h03);
        check_eq("xo_overrun", overrun, 1);
        check_eq("xo_valid", cmd_valid, 0);
        check_eq("xo_busy", busy, 0);
        idle(1);
        check_eq("xo_overrun_pulse", overrun, 0);

        // Reset in WAIT_ADDR
        cmd_ready = 1'b0;
        strobe(8'h06);
        check_eq("rw_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check_all_zero("rw");
        idle(2);
        check_all_zero("rw_hold");
        reset_n = 1'b1;
        idle(1);
        check_eq("rw_fe", frame_error, 0);

        // Reset in ISSUE
        strobe(8'h03);
        strobe(8'h04);
        check_eq("ri_valid", cmd_valid, 1);
        reset_n = 1'b0;
        #1;
        check_all_zero("ri");
        idle(2);
        reset_n = 1'b1;
        idle(1);
        check_eq("ri_ovr_fe", {overrun, frame_error}, 0);

        // First byte after reset is a command
        cmd_ready = 1'b1;
        strobe(8'h00);
        check_eq("rn_busy", busy, 1);
        exp_q.push_back({8'h00, 5'h00});
        strobe(8'h00);
        check_eq("rn_valid", cmd_valid, 1);
        idle(2);

        check_eq("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
